// File: rtl/uop_serializer_ctrl_pkg.sv
// Shared types for the uop serializer: instruction classes and controller states.
package uop_serializer_ctrl_pkg;

  localparam int unsigned ITYPE_LEN = 3;

  typedef enum logic [ITYPE_LEN-1:0] {
    STD       = 3'd0,
    EXC       = 3'd1,
    INT       = 3'd2,
    BR_NTAKEN = 3'd3,
    BR_TAKEN  = 3'd4,
    JUMP      = 3'd5,
    RETURN    = 3'd6
  } itype_e;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } ser_state_e;

  // An exception or interrupt ends the row; later slots are discarded.
  function automatic logic is_term(input itype_e t);
    return (t == EXC) || (t == INT);
  endfunction

  // Anything but a plain instruction counts toward block grouping.
  function automatic logic is_special(input itype_e t);
    return t != STD;
  endfunction

endpackage

// File: rtl/uop_serializer_ctrl_first_valid.sv
// Masked priority encoder: first set bit at or above a start index, and
// whether any set bit lies beyond it.
module uop_serializer_ctrl_first_valid #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]           i_vec,
  input  logic [$clog2(N):0]     i_start,
  output logic [$clog2(N)-1:0]   o_idx,
  output logic                   o_found,
  output logic                   o_any_after
);

  localparam int unsigned SW = $clog2(N);
  localparam int unsigned CW = SW + 1;

  logic          w_found;
  logic [SW-1:0] w_idx;
  logic          w_any_after;

  // Lowest-index valid slot not below the start pointer.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (!w_found && i_vec[i] && (CW'(i) >= i_start)) begin
        w_found = 1'b1;
        w_idx   = SW'(i);
      end
    end
  end

  // Any valid slot strictly after the selected one.
  always_comb begin
    w_any_after = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (w_found && i_vec[i] && (SW'(i) > w_idx)) begin
        w_any_after = 1'b1;
      end
    end
  end

  assign o_idx       = w_idx;
  assign o_found     = w_found;
  assign o_any_after = w_any_after;

endmodule

// File: rtl/uop_serializer_ctrl.sv
// Walks each FIFO row slot by slot, presents one uop per handshake, pops the
// row after its last presentable slot and reports the row's special count.
module uop_serializer_ctrl
  import uop_serializer_ctrl_pkg::*;
#(
  parameter int unsigned NRET    = 2,
  parameter int unsigned CNT_LEN = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic                        empty_i,
  input  logic [NRET-1:0]             head_valid_i,
  input  logic [NRET*ITYPE_LEN-1:0]   head_itype_i,
  input  logic                        ready_i,
  output logic                        valid_o,
  output logic [$clog2(NRET)-1:0]     sel_o,
  output logic                        pop_o,
  output logic                        row_last_o,
  output logic [$clog2(NRET):0]       n_special_o,
  output logic                        n_special_vld_o,
  output logic [CNT_LEN-1:0]          emitted_cnt_o
);

  localparam int unsigned SW = $clog2(NRET);
  localparam int unsigned CW = SW + 1;

  ser_state_e         r_state;
  ser_state_e         w_state_n;
  logic [CW-1:0]      r_cur;
  logic [CW-1:0]      w_cur_n;
  logic [CW-1:0]      r_spec;
  logic [CW-1:0]      w_spec_n;
  logic [CNT_LEN-1:0] r_cnt;
  logic [CNT_LEN-1:0] w_cnt_n;

  itype_e             w_itype [NRET];
  itype_e             w_itype_nxt;
  logic [SW-1:0]      w_nxt;
  logic               w_found;
  logic               w_any_after;
  logic               w_term;
  logic               w_inc;

  logic               w_valid;
  logic [SW-1:0]      w_sel;
  logic               w_pop;
  logic               w_last;
  logic [CW-1:0]      w_nsp;
  logic               w_nsp_vld;

  // Unpack per-slot instruction types from the flat head bus.
  always_comb begin
    for (int i = 0; i < int'(NRET); i++) begin
      w_itype[i] = itype_e'(head_itype_i[i*ITYPE_LEN +: ITYPE_LEN]);
    end
  end

  uop_serializer_ctrl_first_valid #(
    .N (NRET)
  ) u_first_valid (
    .i_vec       (head_valid_i),
    .i_start     (r_cur),
    .o_idx       (w_nxt),
    .o_found     (w_found),
    .o_any_after (w_any_after)
  );

  assign w_itype_nxt = w_itype[w_nxt];
  assign w_term      = is_term(w_itype_nxt);
  assign w_inc       = is_special(w_itype_nxt);

  // State, slot pointer, special accumulator and emitted counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cur   <= '0;
      r_spec  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cur   <= w_cur_n;
      r_spec  <= w_spec_n;
      r_cnt   <= w_cnt_n;
    end
  end

  // Next-state and combinational outputs; flush overrides everything.
  always_comb begin
    w_state_n = r_state;
    w_cur_n   = r_cur;
    w_spec_n  = r_spec;
    w_cnt_n   = r_cnt;
    w_valid   = 1'b0;
    w_pop     = 1'b0;
    w_last    = 1'b0;
    w_nsp     = '0;
    w_nsp_vld = 1'b0;
    w_sel     = '0;

    case (r_state)
      IDLE: begin
        if (!empty_i) begin
          w_state_n = ISSUE;
        end
      end
      ISSUE: begin
        w_sel = w_found ? w_nxt : r_cur[SW-1:0];
        if (empty_i) begin
          // Row drained by the previous pop and nothing behind it.
          w_state_n = IDLE;
        end else if (w_found) begin
          w_valid = 1'b1;
          w_last  = w_term || !w_any_after;
          if (ready_i) begin
            w_cnt_n = r_cnt + CNT_LEN'(1);
            if (w_last) begin
              w_pop     = 1'b1;
              w_nsp_vld = 1'b1;
              w_nsp     = r_spec + CW'(w_inc);
              w_cur_n   = '0;
              w_spec_n  = '0;
            end else begin
              w_cur_n  = CW'(w_nxt) + CW'(1);
              w_spec_n = r_spec + CW'(w_inc);
            end
          end
        end else begin
          // Nothing left to present in this row: retire it.
          w_pop     = 1'b1;
          w_nsp_vld = 1'b1;
          w_nsp     = r_spec;
          w_cur_n   = '0;
          w_spec_n  = '0;
        end
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase

    if (flush_i) begin
      w_valid   = 1'b0;
      w_last    = 1'b0;
      w_nsp_vld = 1'b0;
      w_nsp     = '0;
      w_pop     = (r_state == ISSUE) && !empty_i;
      w_cnt_n   = r_cnt;
      w_cur_n   = '0;
      w_spec_n  = '0;
      w_state_n = IDLE;
    end
  end

  assign valid_o         = w_valid;
  assign sel_o           = w_sel;
  assign pop_o           = w_pop;
  assign row_last_o      = w_last;
  assign n_special_o     = w_nsp;
  assign n_special_vld_o = w_nsp_vld;
  assign emitted_cnt_o   = r_cnt;

endmodule

// File: tb/tb_uop_serializer_ctrl.sv
// Directed bench for uop_serializer_ctrl (NRET=2) with a row-list reference model.
module tb_uop_serializer_ctrl;
  import uop_serializer_ctrl_pkg::*;

  typedef struct packed {
    logic [1:0] v;
    logic [2:0] t1;
    logic [2:0] t0;
  } row_t;

  logic        clk;
  logic        rst_ni;
  logic        flush_i;
  logic        empty_i;
  logic [1:0]  head_valid_i;
  logic [5:0]  head_itype_i;
  logic        ready_i;
  logic        valid_o;
  logic        sel_o;
  logic        pop_o;
  logic        row_last_o;
  logic [1:0]  n_special_o;
  logic        n_special_vld_o;
  logic [15:0] emitted_cnt_o;

  uop_serializer_ctrl #(.NRET(2), .CNT_LEN(16)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .flush_i         (flush_i),
    .empty_i         (empty_i),
    .head_valid_i    (head_valid_i),
    .head_itype_i    (head_itype_i),
    .ready_i         (ready_i),
    .valid_o         (valid_o),
    .sel_o           (sel_o),
    .pop_o           (pop_o),
    .row_last_o      (row_last_o),
    .n_special_o     (n_special_o),
    .n_special_vld_o (n_special_vld_o),
    .emitted_cnt_o   (emitted_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   total = 0;
  int   bad   = 0;
  row_t q[$];
  int   pop_req = 0;
  int   pops_done = 0;

  // Model state: row in hand, presented slots accepted so far, uops emitted.
  bit   m_issue = 0;
  int   m_k = 0;
  int   m_cnt = 0;

  // DUT activity logs for literal checks (digits are value+1, base 4).
  int   hs_n = 0, hs_code = 0, last_code = 0;
  int   nsp_n = 0, nsp_code = 0;
  int   pops = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic upd_heads();
    row_t r;
    if (q.size() > 0) begin
      r            = q[0];
      empty_i      = 1'b0;
      head_valid_i = r.v;
      head_itype_i = {r.t1, r.t0};
    end else begin
      empty_i      = 1'b1;
      head_valid_i = 2'b00;
      head_itype_i = 6'd0;
    end
  endtask

  task automatic push(input logic [1:0] v, input itype_e t1, input itype_e t0);
    row_t r;
    r.v  = v;
    r.t1 = t1;
    r.t0 = t0;
    q.push_back(r);
    upd_heads();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    while (pops_done < pop_req) begin
      if (q.size() > 0) void'(q.pop_front());
      pops_done++;
    end
    upd_heads();
  endtask

  task automatic clr_logs();
    hs_n = 0; hs_code = 0; last_code = 0;
    nsp_n = 0; nsp_code = 0; pops = 0;
  endtask

  task automatic drain(input string nm, input int max_cyc);
    int n;
    n = 0;
    while (!(q.size() == 0 && !m_issue) && n < max_cyc) begin
      step();
      n++;
    end
    chk(nm, int'(n >= max_cyc), 0);
  endtask

  // Reference model plus per-cycle comparison, sampled on the falling edge.
  task automatic compare_loop();
    row_t r;
    int   lst[$];
    int   nspec;
    logic [2:0] t;
    bit   emp, e_valid, e_last, e_pop, e_nvld;
    int   e_sel, e_nsp;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        m_issue = 0; m_k = 0; m_cnt = 0;
        continue;
      end
      emp = (q.size() == 0);
      lst = {};
      nspec = 0;
      if (!emp) begin
        r = q[0];
        for (int i = 0; i < 2; i++) begin
          if (r.v[i]) begin
            lst.push_back(i);
            t = (i == 0) ? r.t0 : r.t1;
            if (t != 3'(STD)) nspec++;
            if (t == 3'(EXC) || t == 3'(INT)) break;
          end
        end
      end
      e_valid = 0; e_last = 0; e_pop = 0; e_nvld = 0; e_sel = 0; e_nsp = 0;
      if (flush_i) begin
        e_pop = m_issue && !emp;
      end else if (m_issue && !emp) begin
        if (m_k < lst.size()) begin
          e_valid = 1;
          e_sel   = lst[m_k];
          e_last  = (m_k == lst.size() - 1);
          if (ready_i && e_last) begin
            e_pop = 1; e_nvld = 1; e_nsp = nspec;
          end
        end else begin
          e_pop = 1; e_nvld = 1; e_nsp = nspec;
        end
      end
      chk("valid_o", int'(valid_o), int'(e_valid));
      chk("row_last_o", int'(row_last_o), int'(e_last));
      chk("pop_o", int'(pop_o), int'(e_pop));
      chk("n_special_vld_o", int'(n_special_vld_o), int'(e_nvld));
      chk("pop_when_empty", int'(pop_o && empty_i), 0);
      chk("emitted_cnt_o", int'(emitted_cnt_o), m_cnt);
      if (e_valid) chk("sel_o", int'(sel_o), e_sel);
      if (e_nvld) chk("n_special_o", int'(n_special_o), e_nsp);

      if (valid_o && ready_i) begin
        hs_n++;
        hs_code   = hs_code * 4 + int'(sel_o) + 1;
        last_code = last_code * 4 + int'(row_last_o) + 1;
      end
      if (pop_o) pops++;
      if (n_special_vld_o) begin
        nsp_n++;
        nsp_code = nsp_code * 4 + int'(n_special_o) + 1;
      end

      if (flush_i) begin
        m_issue = 0; m_k = 0;
      end else if (!m_issue) begin
        m_issue = !emp;
      end else if (emp) begin
        m_issue = 0;
      end else begin
        if (e_valid && ready_i) begin
          m_k++;
          m_cnt = (m_cnt + 1) & 16'hFFFF;
        end
        if (e_pop) m_k = 0;
      end
      if (e_pop) pop_req++;
    end
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    upd_heads();
    fork
      compare_loop();
    join_none

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_pop", int'(pop_o), 0);
    chk("rst_sel", int'(sel_o), 0);
    chk("rst_last", int'(row_last_o), 0);
    chk("rst_nvld", int'(n_special_vld_o), 0);
    chk("rst_cnt", int'(emitted_cnt_o), 0);
    rst_ni = 1'b1;
    step();

    // Two plain slots: sel 0 then 1, pop with the second, no specials.
    clr_logs();
    push(2'b11, STD, STD);
    drain("t1_drain", 20);
    chk("t1_hs", hs_code, 6);
    chk("t1_last", last_code, 6);
    chk("t1_nsp", nsp_code, 1);
    chk("t1_pops", pops, 1);

    // Exception in slot 0 truncates the row.
    clr_logs();
    push(2'b11, STD, EXC);
    drain("t2_drain", 20);
    chk("t2_hs", hs_code, 1);
    chk("t2_last", last_code, 2);
    chk("t2_nsp", nsp_code, 2);
    chk("t2_pops", pops, 1);

    // Only slot 1 valid, a taken branch.
    clr_logs();
    push(2'b10, BR_TAKEN, STD);
    drain("t3_drain", 20);
    chk("t3_hs", hs_code, 2);
    chk("t3_nsp", nsp_code, 2);
    chk("t3_pops", pops, 1);

    // Backpressure on slot 0.
    clr_logs();
    ready_i = 1'b0;
    push(2'b11, STD, STD);
    repeat (5) step();
    chk("t4_hold_hs", hs_n, 0);
    chk("t4_hold_pops", pops, 0);
    chk("t4_hold_valid", int'(valid_o), 1);
    chk("t4_hold_sel", int'(sel_o), 0);
    chk("t4_hold_cnt", int'(emitted_cnt_o), 4);
    ready_i = 1'b1;
    drain("t4_drain", 20);
    chk("t4_hs", hs_code, 6);
    chk("t4_cnt", int'(emitted_cnt_o), 6);

    // Flush during slot 1; next row restarts at slot 0.
    clr_logs();
    push(2'b11, STD, STD);
    push(2'b11, STD, STD);
    step();
    step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    drain("t5_drain", 20);
    chk("t5_hs", hs_code, 22);
    chk("t5_pops", pops, 2);
    chk("t5_nsp", nsp_code, 1);

    // All-invalid row is retired without presenting; interrupt in slot 1.
    clr_logs();
    push(2'b00, STD, STD);
    push(2'b11, INT, STD);
    drain("t6_drain", 20);
    chk("t6_hs", hs_code, 6);
    chk("t6_nsp", nsp_code, 6);
    chk("t6_pops", pops, 2);

    // Reset mid-row: row abandoned, counter cleared.
    clr_logs();
    ready_i = 1'b0;
    push(2'b11, STD, STD);
    repeat (3) step();
    rst_ni = 1'b0;
    q.delete();
    pops_done = pop_req;
    upd_heads();
    repeat (2) step();
    chk("t7_rst_cnt", int'(emitted_cnt_o), 0);
    chk("t7_rst_pops", pops, 0);
    rst_ni = 1'b1;
    ready_i = 1'b1;
    step();

    // Five rows back to back, then empty.
    clr_logs();
    for (int i = 0; i < 5; i++) push(2'b11, STD, STD);
    drain("t8_drain", 40);
    step();
    chk("t8_hs_n", hs_n, 10);
    chk("t8_pops", pops, 5);
    chk("t8_cnt", int'(emitted_cnt_o), 10);
    chk("t8_idle_valid", int'(valid_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
